wb_stage_reg: RTL
=================

# wb_stage_reg

Parametrised MEM→WB pipeline stage register with valid/ready flow control, flush, optional skid buffer and a bubble counter. It carries the write-enable, ALU result, load data and destination register address of one instruction from the memory stage to the writeback stage. Unlike a fixed always-advance latch, it can stall, absorb one extra in-flight instruction, and kill its contents on a pipeline flush. It sits between the data-memory stage and the register-file write port.

## Interface
- `DATA_W`, 32, width of ALU result and load data
- `REG_W`, 5, width of destination register address
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`
- `CNT_W`, 16, width of the bubble counter
- Reset `rst` is synchronous and active-high; the clock is `clk`.
- `clk  in  1  clock`
- `rst  in  1  synchronous active-high reset`
- `flush  in  1  discard all held and incoming entries this cycle`
- `in_valid  in  1  MEM stage presents an instruction`
- `in_ready  out  1  stage accepts the instruction this cycle`
- `in_we  in  1  register-file write enable`
- `in_alu  in  DATA_W  ALU result`
- `in_rdata  in  DATA_W  load data`
- `in_waddr  in  REG_W  destination register`
- `out_valid  out  1  WB stage has an instruction`
- `out_ready  in  1  WB stage consumes it this cycle`
- `out_we  out  1  gated write enable`
- `out_alu  out  DATA_W  ALU result`
- `out_rdata  out  DATA_W  load data`
- `out_waddr  out  REG_W  destination register`
- `occupancy  out  2  number of held entries (0–2)`
- `bubble_cnt  out  CNT_W  saturating count of WB bubble cycles`

## Operation
- Define push = `in_valid & in_ready` and pop = `out_valid & out_ready`.
- There are two slots, MAIN and SKID. Outputs always come from MAIN.
- The state is given by the valid bits: EMPTY (0 entries), ONE (MAIN valid), FULL (MAIN and SKID valid). FULL is reachable only when SKID=1.
- Transitions:
  - EMPTY: push → ONE, and MAIN loads the input.
  - ONE:
    - push & pop → ONE, and MAIN loads the input.
    - push & !pop → FULL, and SKID loads the input.
    - pop & !push → EMPTY.
  - FULL: no push is possible. pop → ONE, and MAIN loads SKID.
- `in_ready`:
  - SKID=1: `in_ready` = !SKID_valid, a function of state only.
  - SKID=0: `in_ready` = !MAIN_valid | `out_ready`.
- Priority is `rst` > `flush` > normal operation.
- `flush`:
  - Both valid bits clear and the state goes to EMPTY.
  - A push in the same cycle is discarded. `in_ready` is not modified by `flush`.
- Zero-register kill: an entry captured with `in_waddr`==0 has its `we` stored as 0.
- `out_we` = MAIN_we & MAIN_valid, so it is never 1 while `out_valid`=0.
- `bubble_cnt`:
  - Increments when `out_ready`=1 & `out_valid`=0.
  - Saturates at 2^CNT_W−1.
  - It is not cleared by `flush`, only by `rst`.
- Data fields are not cleared by `flush`. Their values are don't-care while invalid, except for `out_we`.
- `occupancy` = MAIN_valid + SKID_valid.

## Timing
- Reset values: `out_valid`=0, `out_we`=0, `out_alu`=0, `out_rdata`=0, `out_waddr`=0, `occupancy`=0, `bubble_cnt`=0. `in_ready`=1 during and after reset.
- Latency: an instruction pushed in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY, or when it was ONE with a pop.
- Throughput is one instruction per cycle while `out_ready` stays high.
- SKID=1: after `out_ready` drops, one more instruction is accepted. `in_ready` falls on the next edge.
- Data order is strictly FIFO: MAIN is always older than SKID.
- When `flush` and `rst` are asserted together, reset wins. When `flush` and pop occur together, the WB stage sees the pop as consumed, but no data remains afterward.
- `rst` asserted mid-stall clears FULL to EMPTY in one cycle.

## Test plan
- Reset, then streaming: push alu=0x10..0x13 (waddr 1..4, we=1) on consecutive cycles with `out_ready`=1 → outputs appear one cycle later in order, `occupancy`=1, `bubble_cnt` stops after the first cycle.
- Stall with SKID=1: push A=0xAA and B=0xBB with `out_ready`=0 → `occupancy`=2, `in_ready`=0, `out_alu`=0xAA held. Raise `out_ready` → 0xAA then 0xBB, and `in_ready` returns to 1.
- SKID=0 stall: `out_ready`=0 while ONE → `in_ready`=0 in the same cycle. Push with `out_ready`=1 → replacement without a bubble.
- Flush: in state FULL, assert `flush` together with `in_valid` carrying 0xCC → next cycle `out_valid`=0, `out_we`=0, `occupancy`=0, and 0xCC never appears.
- Zero register: push waddr=0, we=1, alu=0x55 → `out_valid`=1, `out_alu`=0x55, `out_we`=0.
- Bubble counter: CNT_W=2, `out_ready`=1 with no input for 5 cycles → `bubble_cnt`=3 (saturated). Assert `rst` → 0.

Source files
------------

// File: rtl/wb_stage_reg.sv
// MEM->WB stage register: valid/ready handshake, flush, optional two-entry skid
// buffer and a saturating counter of cycles where WB was ready but got nothing.
module wb_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_we_i,
  input  logic [DATA_W-1:0] in_alu_i,
  input  logic [DATA_W-1:0] in_rdata_i,
  input  logic [REG_W-1:0]  in_waddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_we_o,
  output logic [DATA_W-1:0] out_alu_o,
  output logic [DATA_W-1:0] out_rdata_o,
  output logic [REG_W-1:0]  out_waddr_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [REG_W-1:0]  waddr;
  } ent_t;

  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;

  state_t           state_q, state_d;
  ent_t             main_q, main_d, skid_q, skid_d, in_ent;
  logic [CNT_W-1:0] bub_q, bub_d;
  logic             main_v, skid_v, push, pop;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);
  assign push   = in_valid_i & in_ready_o;
  assign pop    = main_v & out_ready_i;

  // Writes to x0 are killed at capture so WB never has to look at the address.
  assign in_ent = '{we: in_we_i & (|in_waddr_i), alu: in_alu_i,
                    rdata: in_rdata_i, waddr: in_waddr_i};

  generate
    if (SKID) begin : g_skid
      assign in_ready_o = ~skid_v;
    end else begin : g_noskid
      assign in_ready_o = ~main_v | out_ready_i;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (push) begin
        state_d = ONE;
        main_d  = in_ent;
      end
      ONE: begin
        if (push && pop) begin
          main_d = in_ent;
        end else if (push) begin
          state_d = FULL;
          skid_d  = in_ent;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: if (pop) begin
        state_d = ONE;
        main_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // Data may still load under flush; it is dead once the valid bits drop.
    if (flush_i) state_d = EMPTY;
  end

  always_comb begin
    bub_d = bub_q;
    if (out_ready_i && !main_v && !(&bub_q)) bub_d = bub_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      bub_q   <= bub_d;
    end
  end

  assign out_valid_o  = main_v;
  assign out_we_o     = main_q.we & main_v;
  assign out_alu_o    = main_q.alu;
  assign out_rdata_o  = main_q.rdata;
  assign out_waddr_o  = main_q.waddr;
  assign occupancy_o  = {1'b0, main_v} + {1'b0, skid_v};
  assign bubble_cnt_o = bub_q;

endmodule
